// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the up/down counter and its command
// sequencer.
//   OP_*     : 2-bit command opcodes carried on cmd_op
//   state_t  : sequencer FSM states
//   op_is_down: selects counter mode for a RUN command
package counter_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_PAUSE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    function automatic logic op_is_down(input logic [1:0] op);
        return op == OP_DOWN;
    endfunction

endpackage

// File: rtl/counter_cmd_fifo.sv
// counter_cmd_fifo: synchronous command FIFO, DEPTH entries (power of two).
//   clk, reset      : clock, synchronous active-high reset
//   flush           : empties the FIFO next cycle; wins over push and pop
//   push, wdata     : write request (ignored when full)
//   pop, rdata      : read request (ignored when empty); rdata shows the head
//   full, empty     : occupancy flags
module counter_cmd_fifo #(
    parameter int DW    = 14,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][DW-1:0] mem;
    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0]              wptr;
    logic [AW:0]              rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !reset && !flush)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/counter_cmd_seq.sv
// counter_cmd_seq: command sequencer driving the up/down counter.
//   clk, reset          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command push handshake
//   cmd_op/arg/len      : opcode, preload value, active cycle count (0 => 1)
//   abort               : flush queue and end the current command
//   detect              : counter wrap detect feedback
//   enable, preload, preload_data, mode : registered counter controls
//   busy                : command in progress or queued
//   done                : pulse in the last active cycle of a command
//   wrap_cnt            : saturating detect count
// Build option: define CTRL_WRAP_CNT_EN to enable wrap_cnt; otherwise it is
// tied to 0 and detect is ignored.
module counter_cmd_seq
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    input  logic             detect,
    output logic             enable,
    output logic             preload,
    output logic [WIDTH-1:0] preload_data,
    output logic             mode,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] wrap_cnt
);
    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] arg;
        logic [LEN_W-1:0] len;
    } cmd_t;

    cmd_t wcmd;
    cmd_t head;
    logic full;
    logic empty;
    logic pop;

    state_t           state, state_n;
    logic [1:0]       op_q, op_n;
    logic [WIDTH-1:0] arg_q, arg_n;
    logic [LEN_W-1:0] rem, rem_n;

    logic             enable_n, preload_n, mode_n, done_n;
    logic [WIDTH-1:0] pdata_n;

    // Ready does not look ahead at a same-cycle pop.
    assign cmd_ready = !full && !reset && !abort;
    assign wcmd      = '{op: cmd_op, arg: cmd_arg, len: cmd_len};
    assign busy      = (state != ST_IDLE) || !empty;

    counter_cmd_fifo #(
        .DW    ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (abort),
        .push  (cmd_valid && cmd_ready),
        .wdata (wcmd),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Next state. Returning to IDLE after every command gives the one-cycle
    // gap before the next pop.
    always_comb begin
        state_n = state;
        op_n    = op_q;
        arg_n   = arg_q;
        rem_n   = rem;
        pop     = 1'b0;
        if (abort) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        pop   = 1'b1;
                        op_n  = head.op;
                        arg_n = head.arg;
                        rem_n = (head.len == '0) ? '0 : head.len - 1'b1;
                        case (head.op)
                            OP_LOAD:  state_n = ST_LOAD;
                            OP_PAUSE: state_n = ST_PAUSE;
                            default:  state_n = ST_RUN;
                        endcase
                    end
                end
                ST_LOAD: state_n = ST_IDLE;
                default: begin
                    if (rem == '0)
                        state_n = ST_IDLE;
                    else
                        rem_n = rem - 1'b1;
                end
            endcase
        end
    end

    // Outputs are registered, so they are derived from the next state.
    always_comb begin
        enable_n  = (state_n == ST_LOAD) || (state_n == ST_RUN);
        preload_n = (state_n == ST_LOAD);
        pdata_n   = preload_n ? arg_n : '0;
        mode_n    = (state_n == ST_RUN) && op_is_down(op_n);
        done_n    = (state_n == ST_LOAD) ||
                    (((state_n == ST_RUN) || (state_n == ST_PAUSE)) && (rem_n == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            op_q         <= '0;
            arg_q        <= '0;
            rem          <= '0;
            enable       <= 1'b0;
            preload      <= 1'b0;
            preload_data <= '0;
            mode         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            op_q         <= op_n;
            arg_q        <= arg_n;
            rem          <= rem_n;
            enable       <= enable_n;
            preload      <= preload_n;
            preload_data <= pdata_n;
            mode         <= mode_n;
            done         <= done_n;
        end
    end

`ifdef CTRL_WRAP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || abort)
            wrap_cnt <= '0;
        else if (detect && (wrap_cnt != '1))
            wrap_cnt <= wrap_cnt + 1'b1;
    end
`else
    logic unused_detect;
    assign unused_detect = detect;
    assign wrap_cnt      = '0;
`endif

endmodule
